aes_key_sched_seq: RTL

- Iterative, area-lean AES round-key generator for AES-128 and AES-256, selected by parameter.
- Accepts a cipher key over a valid/ready handshake and computes every round key with a single shared S4 instance (4-byte S-box, 1-cycle registered latency).
- Stores the round keys in an internal register file that the iterative cipher cores read by round index.
- Successor to the unrolled, one-expander-per-round key schedule: one datapath, selectable key length, stored and indexed keys, explicit done/busy status.

---
 rtl/aes_key_pkg.sv | 31 +++
 rtl/aes_rk_store.sv | 66 ++++++
 rtl/aes_s4.sv | 42 ++++
 rtl/aes_key_sched_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the iterative AES key schedule: FSM states,
// NK/NR derivation, xtime and the RotWord macro.
`ifndef AES_KEY_PKG_SV
`define AES_KEY_PKG_SV

`define AES_ROT_WORD(w) {w[23:0], w[31:24]}

package aes_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_MIX,
    ST_DONE
  } ks_state_e;

  function automatic int nk_of(input int key_w);
    return key_w / 32;
  endfunction

  function automatic int nr_of(input int key_w);
    return (key_w == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`endif

// File: rtl/aes_rk_store.sv
// Round-key register file: (NR+1) x 128 entries with valid bits, global clear,
// key load, one write port and a registered read port.
module aes_rk_store
  import aes_key_pkg::*;
#(
  parameter int KEY_W = 128,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wipe,
  input  logic             load,
  input  logic [KEY_W-1:0] key,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [127:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rk_out,
  output logic             rk_hit
);

  localparam int NK = nk_of(KEY_W);
  localparam int NENT = nr_of(KEY_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NENT - 1);

  logic [127:0]    mem [NENT];
  logic [NENT-1:0] vld;
  logic            rd_in_range;
  logic            rd_hit;

  // A load or wipe invalidates everything at once, and an entry being written
  // this cycle still reads as its pre-write (unwritten) state.
  assign rd_in_range = (rd_idx <= LAST_IDX);
  assign rd_hit = rd_in_range && vld[rd_idx] && !wipe && !load &&
                  !(we && (wr_idx == rd_idx));

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the entries are reset explicitly because a freshly reset store must
    // read back as all zeros; a plain RAM without reset could not promise that.
    if (!reset_n) begin
      for (int e = 0; e < NENT; e++) mem[e] <= '0;
      vld    <= '0;
      rk_out <= '0;
      rk_hit <= 1'b0;
    end else begin
      if (wipe) begin
        for (int e = 0; e < NENT; e++) mem[e] <= '0;
        vld <= '0;
      end else if (load) begin
        vld    <= '0;
        mem[0] <= key[KEY_W-1 -: 128];
        vld[0] <= 1'b1;
        if (NK == 8) begin
          mem[1] <= key[127:0];
          vld[1] <= 1'b1;
        end
      end else if (we) begin
        mem[wr_idx] <= wr_data;
        vld[wr_idx] <= 1'b1;
      end
      rk_hit <= rd_hit;
      rk_out <= rd_hit ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/aes_s4.sv
// Four parallel AES S-boxes (SubWord) with one registered pipeline stage.
module aes_s4 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!reset_n) begin
      dout <= '0;
    end else begin
      dout <= {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
    end
  end

endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128/256 round-key generator sharing one S4 across all steps.
// Define KEY_SCHED_ZEROIZE_EN to add the zeroize input.
module aes_key_sched_seq
  import aes_key_pkg::*;
#(
  parameter int KEY_W = 128,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] rk_idx,
  output logic [127:0]     rk_out,
  output logic             rk_hit
);

  localparam int NK = nk_of(KEY_W);
  localparam int NR = nr_of(KEY_W);

  if (KEY_W != 128 && KEY_W != 256) begin : g_bad_key_w
    $error("aes_key_sched_seq: KEY_W must be 128 or 256");
  end
  if ((1 << IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_key_sched_seq: IDX_W too narrow to index round NR");
  end

  ks_state_e        state, state_d;
  logic [KEY_W-1:0] win, win_d;
  logic [7:0]       rcon;
  logic [IDX_W-1:0] rk_cnt;
  logic             odd_step;
  logic             rot_step;
  logic             accept;
  logic             mix_step;
  logic             last_step;
  logic             zap;
  logic [31:0]      w_last, s4_in, s4_out, temp;
  logic [31:0]      nw0, nw1, nw2, nw3;
  logic [127:0]     rk_new;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zap = zeroize;
`else
  assign zap = 1'b0;
`endif

  assign key_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy      = (state == ST_SUB) || (state == ST_MIX);
  assign accept    = key_valid && key_ready && !zap;
  assign mix_step  = (state == ST_MIX);
  assign last_step = (rk_cnt == IDX_W'(NR));

  // AES-256 alternates RotWord+Rcon steps with plain SubWord steps.
  assign rot_step = (NK == 4) || !odd_step;
  assign w_last   = win[31:0];
  assign s4_in    = rot_step ? `AES_ROT_WORD(w_last) : w_last;

  aes_s4 u_s4 (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (s4_in),
    .dout    (s4_out)
  );

  assign temp   = s4_out ^ (rot_step ? {rcon, 24'h0} : 32'h0);
  assign nw0    = win[KEY_W-1  -: 32] ^ temp;
  assign nw1    = win[KEY_W-33 -: 32] ^ nw0;
  assign nw2    = win[KEY_W-65 -: 32] ^ nw1;
  assign nw3    = win[KEY_W-97 -: 32] ^ nw2;
  assign rk_new = {nw0, nw1, nw2, nw3};

  if (NK == 4) begin : g_win128
    assign win_d = rk_new;
  end else begin : g_win256
    assign win_d = {win[127:0], rk_new};
  end

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state;
    case (state)
      ST_IDLE, ST_DONE: if (accept) state_d = ST_SUB;
      ST_SUB:           state_d = ST_MIX;
      ST_MIX:           state_d = last_step ? ST_DONE : ST_SUB;
      default:          state_d = ST_IDLE;
    endcase
    if (zap) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      win      <= '0;
      rcon     <= 8'h01;
      rk_cnt   <= '0;
      odd_step <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_d;
      done  <= mix_step && last_step && !zap;
      if (zap) begin
        win      <= '0;
        rcon     <= '0;
        rk_cnt   <= '0;
        odd_step <= 1'b0;
      end else if (accept) begin
        win      <= key_in;
        rcon     <= 8'h01;
        rk_cnt   <= IDX_W'(NK / 4);
        odd_step <= 1'b0;
      end else if (mix_step) begin
        win      <= win_d;
        rk_cnt   <= rk_cnt + 1'b1;
        odd_step <= ~odd_step;
        if (rot_step) rcon <= xtime(rcon);
      end
    end
  end

  aes_rk_store #(
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .wipe    (zap),
    .load    (accept),
    .key     (key_in),
    .we      (mix_step && !zap),
    .wr_idx  (rk_cnt),
    .wr_data (rk_new),
    .rd_idx  (rk_idx),
    .rk_out  (rk_out),
    .rk_hit  (rk_hit)
  );

endmodule
